// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Types and constants shared by the data-memory arbiter and its priority
// helper.
//   state_e      : arbiter sequencing state (IDLE, core read owed, DMA read owed)
//   sel_e        : which requester owns the memory port this cycle
//   MEMCTRL_WORD : memctrl encoding for a full-word access (the only DMA size)
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // free to accept one access this cycle
    CRD  = 2'd1,  // core load data returns this cycle
    DRD  = 2'd2   // DMA read data returns this cycle
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CORE = 2'd1,
    SEL_DMA  = 2'd2
  } sel_e;

  localparam logic [2:0] MEMCTRL_WORD = 3'b010;

endpackage : dmem_pkg

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles the three buses around the data-memory arbiter:
//   core side : corereqM/corewriteM/coreaddrM/corectrlM/corewdataM in,
//               corerdataM/corestallM out
//   DMA side  : dmareq/dmawrite/dmaaddr/dmawdata in,
//               dmagnt/dmardata/dmarvalid out
//   memory    : memaddr/memwe/memre/memctrl/memwdata out, memrdata in
// slave  = the arbiter's view, master = the surrounding system's view.
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
);

  // Core memory stage
  logic                  corereqM;
  logic                  corewriteM;
  logic [ADDR_WIDTH-1:0] coreaddrM;
  logic [2:0]            corectrlM;
  logic [DATA_WIDTH-1:0] corewdataM;
  logic [DATA_WIDTH-1:0] corerdataM;
  logic                  corestallM;

  // DMA / loader port
  logic                  dmareq;
  logic                  dmawrite;
  logic [ADDR_WIDTH-1:0] dmaaddr;
  logic [DATA_WIDTH-1:0] dmawdata;
  logic                  dmagnt;
  logic [DATA_WIDTH-1:0] dmardata;
  logic                  dmarvalid;

  // Data memory
  logic [ADDR_WIDTH-1:0] memaddr;
  logic                  memwe;
  logic                  memre;
  logic [2:0]            memctrl;
  logic [DATA_WIDTH-1:0] memwdata;
  logic [DATA_WIDTH-1:0] memrdata;

  modport slave (
    input  corereqM, corewriteM, coreaddrM, corectrlM, corewdataM,
    output corerdataM, corestallM,
    input  dmareq, dmawrite, dmaaddr, dmawdata,
    output dmagnt, dmardata, dmarvalid,
    output memaddr, memwe, memre, memctrl, memwdata,
    input  memrdata
  );

  modport master (
    output corereqM, corewriteM, coreaddrM, corectrlM, corewdataM,
    input  corerdataM, corestallM,
    output dmareq, dmawrite, dmaaddr, dmawdata,
    input  dmagnt, dmardata, dmarvalid,
    input  memaddr, memwe, memre, memctrl, memwdata,
    output memrdata
  );

endinterface : dmem_arbiter_if

// File: rtl/dmem_arb_prio.sv
// -----------------------------------------------------------------------------
// dmem_arb_prio
// Combinational grant decision for the shared data-memory port.
//   corereq, dmareq : pending requests
//   waitcnt         : consecutive cycles the DMA has been refused
//   state           : arbiter state; only IDLE may issue a new access
//   sel             : requester granted this cycle (SEL_NONE if none)
// The core normally wins; a DMA that has waited MAX_WAIT cycles takes the
// port so it cannot be starved by a busy pipeline.
// -----------------------------------------------------------------------------
module dmem_arb_prio
  import dmem_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WCNT_W   = 3
) (
  input  logic              corereq,
  input  logic              dmareq,
  input  logic [WCNT_W-1:0] waitcnt,
  input  state_e            state,
  output sel_e              sel
);

  logic dma_starved;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the ifs can leave it unassigned and infer a latch.
  always_comb begin
    sel         = SEL_NONE;
    dma_starved = dmareq && (waitcnt >= WCNT_W'(MAX_WAIT));
    if (state == IDLE) begin
      if (corereq && !dma_starved) begin
        sel = SEL_CORE;
      end else if (dmareq) begin
        sel = SEL_DMA;
      end
    end
  end

endmodule : dmem_arb_prio

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port synchronous data memory between the core M stage
// and a DMA/loader port.
//   clk : clock
//   rst : synchronous, active-high reset
//   bus : dmem_arbiter_if.slave (core, DMA and memory buses)
// Stores and DMA writes finish in the grant cycle. Reads take two cycles:
// the grant cycle drives memre, the following cycle (CRD or DRD) forwards
// memrdata to the requester and issues nothing new. corestallM holds the
// pipeline while a core load is outstanding or the core has lost the port.
// All outputs are forced to zero while rst is high, so a read caught by
// reset never produces a response.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int MAX_WAIT   = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   waitcnt_q, waitcnt_d;
  sel_e                sel;

  logic [ADDR_WIDTH-1:0] addr_mux;
  logic [DATA_WIDTH-1:0] wdata_mux;

  dmem_arb_prio #(
    .MAX_WAIT (MAX_WAIT),
    .WCNT_W   (WCNT_W)
  ) u_prio (
    .corereq (bus.corereqM),
    .dmareq  (bus.dmareq),
    .waitcnt (waitcnt_q),
    .state   (state_q),
    .sel     (sel)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      waitcnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitcnt_q <= waitcnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    waitcnt_d      = waitcnt_q;
    addr_mux       = '0;
    wdata_mux      = '0;
    bus.memctrl    = '0;
    bus.memwe      = 1'b0;
    bus.memre      = 1'b0;
    bus.corestallM = 1'b0;
    bus.corerdataM = '0;
    bus.dmagnt     = 1'b0;
    bus.dmardata   = '0;
    bus.dmarvalid  = 1'b0;

    if (!rst) begin
      case (state_q)
        IDLE: begin
          case (sel)
            SEL_CORE: begin
              addr_mux    = bus.coreaddrM;
              wdata_mux   = bus.corewdataM;
              bus.memctrl = bus.corectrlM;
              if (bus.corewriteM) begin
                bus.memwe = 1'b1;
              end else begin
                bus.memre      = 1'b1;
                bus.corestallM = 1'b1;
                state_d        = CRD;
              end
            end
            SEL_DMA: begin
              addr_mux       = bus.dmaaddr;
              wdata_mux      = bus.dmawdata;
              bus.memctrl    = MEMCTRL_WORD;
              bus.dmagnt     = 1'b1;
              // The core, if requesting, lost arbitration and must hold.
              bus.corestallM = bus.corereqM;
              if (bus.dmawrite) begin
                bus.memwe = 1'b1;
              end else begin
                bus.memre = 1'b1;
                state_d   = DRD;
              end
            end
            default: ;
          endcase
        end
        CRD: begin
          bus.corerdataM = bus.memrdata;
          state_d        = IDLE;
        end
        DRD: begin
          bus.dmardata   = bus.memrdata;
          bus.dmarvalid  = 1'b1;
          bus.corestallM = bus.corereqM;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // Starvation counter: counts refused DMA cycles, saturating.
      if (bus.dmagnt) begin
        waitcnt_d = '0;
      end else if (bus.dmareq && (waitcnt_q < WCNT_W'(MAX_WAIT))) begin
        waitcnt_d = waitcnt_q + 1'b1;
      end
    end
  end

  assign bus.memaddr  = addr_mux;
  assign bus.memwdata = wdata_mux;

endmodule : dmem_arbiter
